// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus read cycle: the FSM states,
// the default phase lengths and the width of the phase counter.
package rtc_bus_pkg;

  localparam int CNT_W      = 4;
  localparam int T_ADDR_DEF = 4;
  localparam int T_GAP_DEF  = 2;
  localparam int T_RD_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/rtc_bus_reader_if.sv
// Multiplexed address/data bus and strobes between the reader and the RTC pad ring.
// The tristate pad itself lives outside the reader and resolves bus_out/bus_oe into bus_in.
interface rtc_bus_reader_if;

  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       cs_n;
  logic       ad_n;
  logic       rd_n;
  logic       wr_n;

  modport master (
    input  bus_in,
    output bus_out, bus_oe, cs_n, ad_n, rd_n, wr_n
  );

  modport slave (
    output bus_in,
    input  bus_out, bus_oe, cs_n, ad_n, rd_n, wr_n
  );

endinterface

// File: rtl/rtc_bus_timer.sv
// Loadable down-counter that times each bus phase; zero marks the last cycle of a phase.
module rtc_bus_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // A load takes priority; otherwise the counter stops once it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_reader.sv
// Read-only sequencer for a multiplexed-bus RTC: address phase, turnaround, read strobe, done pulse.
// Optional macro RTC_RD_CLEAR_EN adds a synchronous 'clear' input that zeroes data_out.
module rtc_bus_reader
  import rtc_bus_pkg::*;
#(
  parameter int T_ADDR = T_ADDR_DEF,
  parameter int T_GAP  = T_GAP_DEF,
  parameter int T_RD   = T_RD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       addr,
`ifdef RTC_RD_CLEAR_EN
  input  logic             clear,
`endif
  rtc_bus_reader_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [7:0]       data_out
);

  localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_RD   = CNT_W'(T_RD - 1);

  state_t           state;
  state_t           state_nxt;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             sample;
  logic [7:0]       addr_q;

  rtc_bus_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Each phase entry reloads the shared timer with its length minus one.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ADDR;
          tmr_load  = 1'b1;
          tmr_val   = LD_ADDR;
        end
      end
      ADDR: begin
        if (tmr_zero) begin
          state_nxt = GAP;
          tmr_load  = 1'b1;
          tmr_val   = LD_GAP;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_nxt = READ;
          tmr_load  = 1'b1;
          tmr_val   = LD_RD;
        end
      end
      READ: begin
        if (tmr_zero) begin
          state_nxt = DONE;
          sample    = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (state == IDLE && start) begin
      addr_q <= addr;
    end
  end

  // With the clear option, a clear on the sampling edge beats the captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
`ifdef RTC_RD_CLEAR_EN
    end else if (clear) begin
      data_out <= '0;
`endif
    end else if (sample) begin
      data_out <= bus.bus_in;
    end
  end

  always_comb begin
    bus.bus_out = '0;
    bus.bus_oe  = 1'b0;
    bus.cs_n    = 1'b1;
    bus.ad_n    = 1'b1;
    bus.rd_n    = 1'b1;
    bus.wr_n    = 1'b1;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      ADDR: begin
        bus.cs_n    = 1'b0;
        bus.ad_n    = 1'b0;
        bus.bus_oe  = 1'b1;
        bus.bus_out = addr_q;
      end
      GAP: begin
        bus.cs_n = 1'b0;
      end
      READ: begin
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/rtc_bus_reader.md
RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 T_ADDR, 4, clock cycles the address phase lasts (ad_n low, address driven); legal range 1..15.
REQ-002 T_GAP, 2, clock cycles of bus turnaround between address and read phases; legal range 1..15.
REQ-003 T_RD, 4, clock cycles rd_n is held low; legal range 1..15.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; logic held in reset while low.
REQ-006 start  in  1  request a read cycle; sampled only in IDLE.
REQ-007 addr  in  8  RTC register address; captured when start is accepted.
REQ-008 bus_in  in  8  multiplexed address/data bus value from the top-level tristate pad.
REQ-009 bus_out  out  8  value driven onto the multiplexed bus.
REQ-010 bus_oe  out  1  high = bus_out drives the pad.
REQ-011 cs_n, ad_n, rd_n, wr_n  out  1 each  active-low RTC strobes.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse; data_out valid from this cycle on.
REQ-014 data_out  out  8  last byte read; held until the next done or a clear.

Function
REQ-015 The block SHALL implement FSM states IDLE, ADDR, GAP, READ, DONE, encoded with a shared enumeration.
REQ-016 IDLE -> ADDR on the rising edge where start=1; addr SHALL be latched on that edge; start in any other state SHALL be ignored.
REQ-017 ADDR SHALL last exactly T_ADDR cycles: cs_n=0, ad_n=0, rd_n=1, bus_oe=1, bus_out=latched addr.
REQ-018 GAP SHALL last exactly T_GAP cycles: cs_n=0, ad_n=1, rd_n=1, bus_oe=0, bus_out=0.
REQ-019 READ SHALL last exactly T_RD cycles: cs_n=0, rd_n=0, bus_oe=0; bus_in SHALL be sampled into data_out at the rising edge ending the last READ cycle.
REQ-020 DONE SHALL last one cycle: done=1, cs_n=1, rd_n=1, bus_oe=0; then unconditionally IDLE.
REQ-021 Latency: start accepted at edge k -> done high during cycle k+T_ADDR+T_GAP+T_RD+1 (k+11 with defaults).
REQ-022 wr_n SHALL be constantly 1; bus_oe and rd_n=0 SHALL never be asserted in the same cycle.
REQ-023 start held high continuously SHALL yield back-to-back transactions separated by exactly one IDLE cycle.
REQ-024 A single phase counter (4 bits) SHALL be loaded with the phase length minus one on state entry and decrement to zero.

Reset
REQ-025 On reset low, immediately: state=IDLE, counter=0, cs_n=ad_n=rd_n=wr_n=1, bus_oe=0, bus_out=0, busy=0, done=0, data_out=0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no done pulse and data_out=0; first start after release begins a fresh ADDR phase.

Configuration
REQ-027 Macro RTC_RD_CLEAR_EN: when defined, an extra input clear (1 bit) SHALL synchronously zero data_out in any state; clear coinciding with the READ sample edge SHALL win (data_out=0, done still pulses).
REQ-028 Without RTC_RD_CLEAR_EN the clear port SHALL not exist and data_out changes only at reset or READ sampling.

Structure
REQ-029 Package rtc_bus_pkg SHALL hold the FSM state enumeration, default T_ADDR/T_GAP/T_RD constants and the 4-bit counter width.
REQ-030 One sub-module, rtc_bus_timer (loadable 4-bit down-counter with zero flag), SHALL be instantiated for phase timing; tristate pad stays at top level.

Verification
REQ-031 Defaults, addr=8'h21, bus_in=8'h37 during READ, start pulse -> ADDR 4 cycles bus_out=8'h21, done at k+11, data_out=8'h37.
REQ-032 start pulsed again at cycles k+3 and k+9 -> ignored; exactly one done, busy high k+1..k+11.
REQ-033 start held high, addr 8'h22 then 8'h23 -> two done pulses 12 cycles apart, data_out updates each time.
REQ-034 reset low at cycle k+8 (READ) -> all strobes 1, bus_oe=0, data_out=0 same cycle, no done pulse.
REQ-035 T_ADDR=T_GAP=T_RD=1 -> done at k+4; bus_oe and rd_n=0 never overlap (assertion every cycle).
REQ-036 With RTC_RD_CLEAR_EN, clear=1 on the READ sample edge with bus_in=8'hFF -> done pulses, data_out=8'h00.
